pl_interrupt_controller: RTL and testbench

Parametrised successor to the fixed 4-register PL interrupt manager. Provides NUM_IRQ fabric interrupt channels behind an AXI4-Lite slave, with per-channel enable, level/edge mode, polarity, pending with write-1-to-clear (W1C), and software set. All channels combine into one registered irq_out that feeds a PS IRQ_F2P line.

---
 rtl/pl_interrupt_controller_pkg.sv | 17 +
 rtl/pl_interrupt_controller_if.sv | 32 +++
 rtl/pl_irq_sync.sv | 31 +++
 rtl/pl_interrupt_controller.sv | 165 ++++++++++++++++
 tb/tb_pl_interrupt_controller.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/pl_interrupt_controller_pkg.sv
// Shared constants for the PL interrupt controller: register word offsets,
// AXI response code and the write/read channel FSM state encodings.
package pl_intc_pkg;
  localparam logic [2:0] REG_RAW     = 3'd0;
  localparam logic [2:0] REG_PENDING = 3'd1;
  localparam logic [2:0] REG_ENABLE  = 3'd2;
  localparam logic [2:0] REG_MODE    = 3'd3;
  localparam logic [2:0] REG_POL     = 3'd4;
  localparam logic [2:0] REG_ACTIVE  = 3'd5;
  localparam logic [2:0] REG_SOFTSET = 3'd6;
  localparam logic [2:0] REG_CTRL    = 3'd7;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;
endpackage

// File: rtl/pl_interrupt_controller_if.sv
// AXI4-Lite bundle between the PS-side master and the interrupt controller.
interface pl_interrupt_controller_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid, awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid, wready;
  logic [1:0]          bresp;
  logic                bvalid, bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid, arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid, rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/pl_irq_sync.sv
// One interrupt channel front end: N-flop synchroniser, polarity correction
// and a rising-edge detector on the corrected signal.
module pl_irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_i,
  input  logic pol_i,
  output logic raw_o,
  output logic rise_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // synchroniser shift chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], irq_i};
  end

  assign raw_o = sync_q[STAGES-1] ^ pol_i;

  // previous corrected sample, so a polarity flip can register as an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= raw_o;
  end

  assign rise_o = raw_o & ~prev_q;
endmodule

// File: rtl/pl_interrupt_controller.sv
// NUM_IRQ-channel fabric interrupt controller behind an AXI4-Lite slave.
// Optional build macro PL_INTC_VECTOR_EN: offset 0x18 reads back a
// fixed-priority VECTOR (bit31 valid, [4:0] lowest active channel).
module pl_interrupt_controller
  import pl_intc_pkg::*;
#(
  parameter int NUM_IRQ            = 8,
  parameter int SYNC_STAGES        = 2,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [NUM_IRQ-1:0]     irq_in,
  output logic                   irq_out,
  pl_interrupt_controller_if.slave s_axi
);
  localparam int DW = C_S_AXI_DATA_WIDTH;

  wr_state_e wst_q, wst_d;
  rd_state_e rst_q, rst_d;
  logic wr_fire, rd_fire;

  logic [NUM_IRQ-1:0] raw, rise, hw_set, w1c, sset;
  logic [NUM_IRQ-1:0] pending_q, pending_d, enable_q, mode_q, pol_q;
  logic               gie_q, irq_q;
  logic [DW-1:0]      bmask, wbits, rd_mux, rdata_q, vec;
  logic [NUM_IRQ-1:0] bm_n, wb_n, active;
  logic [2:0]         waddr, raddr;
  logic               unused_ok;

  // per-channel synchroniser / edge detector lanes
  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_ch
    pl_irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk(ACLK), .rst(ARESET), .irq_i(irq_in[g]), .pol_i(pol_q[g]),
      .raw_o(raw[g]), .rise_o(rise[g])
    );
  end

  assign hw_set = (mode_q & rise) | (~mode_q & raw);
  assign active = pending_q & enable_q;
  assign waddr  = s_axi.awaddr[4:2];
  assign raddr  = s_axi.araddr[4:2];
  assign bmask  = {{8{s_axi.wstrb[3]}}, {8{s_axi.wstrb[2]}},
                   {8{s_axi.wstrb[1]}}, {8{s_axi.wstrb[0]}}};
  assign wbits  = s_axi.wdata & bmask;
  assign bm_n   = bmask[NUM_IRQ-1:0];
  assign wb_n   = wbits[NUM_IRQ-1:0];
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr, s_axi.araddr, wbits};

  // write FSM state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) wst_q <= W_IDLE;
    else        wst_q <= wst_d;
  end

  // write FSM next state: accept only when address and data are both present
  always_comb begin
    wst_d = wst_q;
    case (wst_q)
      W_IDLE:  if (s_axi.awvalid && s_axi.wvalid) wst_d = W_RESP;
      W_RESP:  if (s_axi.bready) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  // write FSM outputs
  always_comb begin
    wr_fire      = (wst_q == W_IDLE) && s_axi.awvalid && s_axi.wvalid;
    s_axi.awready = wr_fire;
    s_axi.wready  = wr_fire;
    s_axi.bvalid  = (wst_q == W_RESP);
    s_axi.bresp   = RESP_OKAY;
  end

  // read FSM state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rst_q <= R_IDLE;
    else        rst_q <= rst_d;
  end

  // read FSM next state
  always_comb begin
    rst_d = rst_q;
    case (rst_q)
      R_IDLE:  if (s_axi.arvalid) rst_d = R_DATA;
      R_DATA:  if (s_axi.rready) rst_d = R_IDLE;
      default: rst_d = R_IDLE;
    endcase
  end

  // read FSM outputs
  always_comb begin
    rd_fire       = (rst_q == R_IDLE) && s_axi.arvalid;
    s_axi.arready = rd_fire;
    s_axi.rvalid  = (rst_q == R_DATA);
    s_axi.rresp   = RESP_OKAY;
    s_axi.rdata   = rdata_q;
  end

`ifdef PL_INTC_VECTOR_EN
  // fixed-priority encoder: walk down so the lowest index wins
  always_comb begin
    vec = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (active[i]) vec[4:0] = 5'(i);
    vec[DW-1] = |active;
  end
`else
  assign vec = '0;
`endif

  // read mux from current register state (a same-cycle write is not visible)
  always_comb begin
    rd_mux = '0;
    case (raddr)
      REG_RAW:     rd_mux = DW'(raw);
      REG_PENDING: rd_mux = DW'(pending_q);
      REG_ENABLE:  rd_mux = DW'(enable_q);
      REG_MODE:    rd_mux = DW'(mode_q);
      REG_POL:     rd_mux = DW'(pol_q);
      REG_ACTIVE:  rd_mux = DW'(active);
      REG_SOFTSET: rd_mux = vec;
      REG_CTRL:    rd_mux = DW'(gie_q);
      default:     rd_mux = '0;
    endcase
  end

  // pending update: any set source beats a same-cycle W1C
  always_comb begin
    w1c  = '0;
    sset = '0;
    if (wr_fire && waddr == REG_PENDING) w1c  = wb_n;
    if (wr_fire && waddr == REG_SOFTSET) sset = wb_n;
    pending_d = (pending_q & ~w1c) | hw_set | sset;
  end

  // register file, read capture and combined interrupt output
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      pol_q     <= '0;
      gie_q     <= 1'b0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      irq_q     <= gie_q & (|active);
      if (rd_fire) rdata_q <= rd_mux;
      if (wr_fire) begin
        case (waddr)
          REG_ENABLE: enable_q <= (enable_q & ~bm_n) | wb_n;
          REG_MODE:   mode_q   <= (mode_q & ~bm_n) | wb_n;
          REG_POL:    pol_q    <= (pol_q & ~bm_n) | wb_n;
          REG_CTRL:   if (bmask[0]) gie_q <= s_axi.wdata[0];
          default: ;
        endcase
      end
    end
  end

  assign irq_out = irq_q;
endmodule

// File: tb/tb_pl_interrupt_controller.sv
// Directed-vector bench for pl_interrupt_controller (NUM_IRQ = 8).
module tb_pl_interrupt_controller;
  import pl_intc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq_in = '0;
  logic       irq_out;
  int         n_vec = 0;
  int         n_bad = 0;
  logic [31:0] rd;

  pl_interrupt_controller_if #(.ADDR_W(5), .DATA_W(32)) axi ();

  pl_interrupt_controller #(
    .NUM_IRQ(8), .SYNC_STAGES(2), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)
  ) dut (
    .ACLK(clk), .ARESET(rst), .irq_in(irq_in), .irq_out(irq_out), .s_axi(axi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] ad(input logic [2:0] r);
    return {r, 2'b00};
  endfunction

  task automatic axi_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    int t;
    axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b1;
    #1;
    t = 0;
    while (!axi.awready && t < 20) begin tick(1); t++; end
    if (!axi.awready) chk("awready", {31'b0, axi.awready}, 32'd1);
    tick(1);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    t = 0;
    while (!axi.bvalid && t < 20) begin tick(1); t++; end
    if (!axi.bvalid) chk("bvalid", {31'b0, axi.bvalid}, 32'd1);
    tick(1);
    axi.bready = 1'b0;
  endtask

  task automatic axi_rd(input logic [4:0] a, output logic [31:0] d);
    int t;
    axi.araddr = a; axi.arvalid = 1'b1; axi.rready = 1'b0;
    #1;
    t = 0;
    while (!axi.arready && t < 20) begin tick(1); t++; end
    if (!axi.arready) chk("arready", {31'b0, axi.arready}, 32'd1);
    tick(1);
    axi.arvalid = 1'b0;
    t = 0;
    while (!axi.rvalid && t < 20) begin tick(1); t++; end
    if (!axi.rvalid) chk("rvalid", {31'b0, axi.rvalid}, 32'd1);
    d = axi.rdata;
    axi.rready = 1'b1;
    tick(1);
    axi.rready = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] v;
    axi_rd(a, v);
    chk(tag, v, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

    // reset, then a write left hanging in BRESP and reset again
    tick(3);
    rst = 1'b0;
    tick(2);
    axi.awaddr = ad(REG_ENABLE); axi.wdata = 32'hFF; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    tick(1);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    tick(1);
    chk("bvalid_before_rst", {31'b0, axi.bvalid}, 32'd1);
    rst = 1'b1;
    #100;
    chk("bvalid_in_rst", {31'b0, axi.bvalid}, 32'd0);
    chk("irq_in_rst", {31'b0, irq_out}, 32'd0);
    rst = 1'b0;
    tick(2);
    for (int r = 0; r < 8; r++) rd_chk("reg_after_rst", ad(3'(r)), 32'd0);

    // basic register access
    axi_wr(ad(REG_ENABLE), 32'hFF);
    axi_wr(ad(REG_MODE), 32'h0F);
    axi_wr(ad(REG_POL), 32'h00);
    axi_wr(ad(REG_CTRL), 32'h1);
    rd_chk("enable", ad(REG_ENABLE), 32'hFF);
    rd_chk("mode", ad(REG_MODE), 32'h0F);
    rd_chk("polarity", ad(REG_POL), 32'h00);
    rd_chk("ctrl", ad(REG_CTRL), 32'h1);
    axi_wr(ad(REG_ENABLE), 32'hFFFF_FFFF);
    rd_chk("enable_width", ad(REG_ENABLE), 32'hFF);
    axi_wr(ad(REG_ENABLE), 32'h0, 4'b1110);
    rd_chk("enable_strb", ad(REG_ENABLE), 32'hFF);
    axi_wr(ad(REG_CTRL), 32'hFFFF_FFFF);
    rd_chk("ctrl_upper", ad(REG_CTRL), 32'h1);
    rd_chk("misaligned", 5'h0B, 32'hFF);

    // edge channel 2: one-cycle pulse, irq_out four edges later
    irq_in[2] = 1'b1;
    tick(1);
    irq_in[2] = 1'b0;
    tick(2);
    chk("edge_irq_early", {31'b0, irq_out}, 32'd0);
    tick(1);
    chk("edge_irq_lat", {31'b0, irq_out}, 32'd1);
    rd_chk("edge_pending", ad(REG_PENDING), 32'h04);
    rd_chk("edge_active", ad(REG_ACTIVE), 32'h04);
    axi_wr(ad(REG_PENDING), 32'h04);
    chk("edge_irq_clr", {31'b0, irq_out}, 32'd0);
    rd_chk("edge_pending_clr", ad(REG_PENDING), 32'h00);

    // level channel 5: W1C cannot win while source is held
    irq_in[5] = 1'b1;
    tick(4);
    rd_chk("level_raw", ad(REG_RAW), 32'h20);
    chk("level_irq", {31'b0, irq_out}, 32'd1);
    axi_wr(ad(REG_PENDING), 32'h20);
    rd_chk("level_w1c_held", ad(REG_PENDING), 32'h20);
    irq_in[5] = 1'b0;
    tick(5);
    axi_wr(ad(REG_PENDING), 32'h20);
    rd_chk("level_w1c_drop", ad(REG_PENDING), 32'h00);

    // soft set with masking and global enable
    axi_wr(ad(REG_ENABLE), 32'h7F);
    axi_wr(ad(REG_SOFTSET), 32'h80);
    rd_chk("soft_pending", ad(REG_PENDING), 32'h80);
    rd_chk("soft_active_masked", ad(REG_ACTIVE), 32'h00);
    chk("soft_irq_masked", {31'b0, irq_out}, 32'd0);
    rd_chk("vector_none", ad(REG_SOFTSET), 32'h0);
    axi_wr(ad(REG_ENABLE), 32'hFF);
    chk("soft_irq_unmasked", {31'b0, irq_out}, 32'd1);
    axi_wr(ad(REG_CTRL), 32'h0);
    tick(1);
    chk("gie_off_irq", {31'b0, irq_out}, 32'd0);
    axi_wr(ad(REG_CTRL), 32'h1);
    axi_wr(ad(REG_PENDING), 32'h80);
    rd_chk("soft_clr", ad(REG_PENDING), 32'h00);

    // priority vector (or zero read when the encoder is not built)
    axi_wr(ad(REG_SOFTSET), 32'h28);
    rd_chk("vec_active", ad(REG_ACTIVE), 32'h28);
`ifdef PL_INTC_VECTOR_EN
    rd_chk("vector", ad(REG_SOFTSET), 32'h8000_0003);
`else
    rd_chk("softset_reads0", ad(REG_SOFTSET), 32'h0);
`endif
    axi_wr(ad(REG_PENDING), 32'h28);
    rd_chk("vec_clr", ad(REG_PENDING), 32'h00);

    // zero strobes set nothing
    axi_wr(ad(REG_SOFTSET), 32'hFF, 4'h0);
    rd_chk("softset_nostrb", ad(REG_PENDING), 32'h00);

    // polarity flip on edge channel 0 gives raw=1 and a spurious edge
    axi_wr(ad(REG_POL), 32'h01);
    rd_chk("pol_raw", ad(REG_RAW), 32'h01);
    rd_chk("pol_spurious", ad(REG_PENDING), 32'h01);
    axi_wr(ad(REG_POL), 32'h00);
    axi_wr(ad(REG_PENDING), 32'h01);
    rd_chk("pol_restore", ad(REG_PENDING), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
